// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: default 800x480 panel timing, centred window geometry and stage-1 record,
// shared by the timing generator and the downstream colour stage.
package lcd_timing_pkg;
    localparam int H_ACTIVE = 800;
    localparam int H_PULSE  = 1;
    localparam int H_BP     = 46;
    localparam int H_FP     = 210;
    localparam int V_ACTIVE = 480;
    localparam int V_PULSE  = 5;
    localparam int V_BP     = 5;
    localparam int V_FP     = 40;
    localparam int WIN_X0   = 258;
    localparam int WIN_Y0   = 152;
    localparam int WIN_W    = 284;
    localparam int WIN_H    = 176;
    localparam int ADDR_W   = 16;
    localparam int PIPE_DLY = 2;

    // Back porch is measured from sync start, so the sync pulse is not added separately.
    function automatic int total(input int bp, input int active, input int fp);
        return bp + active + fp;
    endfunction

    localparam int H_TOTAL = total(H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = total(V_BP, V_ACTIVE, V_FP);

    // Syncs are carried active-high internally so an all-zero clear is the idle state.
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        wv;
        logic [10:0] x;
        logic [9:0]  y;
    } stage1_t;
endpackage

// File: rtl/lcd_pipe_dly.sv
// lcd_pipe_dly: WIDTH-bit shift register of DEPTH stages with async active-low clear.
// Ports: clk (clock), rst_n (async clear, active low), din (input word), dout (din delayed DEPTH
// cycles; DEPTH=0 is a plain passthrough).
module lcd_pipe_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = clk & rst_n;
        assign dout = din;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else begin
                sr[0] <= din;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign dout = sr[DEPTH-1];
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: panel HSYNC/VSYNC/DE timing plus row-major address of a window for a sync ROM.
// Ports: PixelClk (clock), nRST (async reset, active low), en (1 = run, 0 = hold at frame start),
// LCD_HSYNC/LCD_VSYNC (active-low syncs) and LCD_DE, delayed to match ROM latency,
// pix_x/pix_y/frame_start (stage-1 position and frame pulse), win_addr/win_valid (ROM address
// and its qualifier), win_valid_d (win_valid aligned with ROM dout).
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = lcd_timing_pkg::H_ACTIVE,
    parameter int H_PULSE  = lcd_timing_pkg::H_PULSE,
    parameter int H_BP     = lcd_timing_pkg::H_BP,
    parameter int H_FP     = lcd_timing_pkg::H_FP,
    parameter int V_ACTIVE = lcd_timing_pkg::V_ACTIVE,
    parameter int V_PULSE  = lcd_timing_pkg::V_PULSE,
    parameter int V_BP     = lcd_timing_pkg::V_BP,
    parameter int V_FP     = lcd_timing_pkg::V_FP,
    parameter int WIN_X0   = lcd_timing_pkg::WIN_X0,
    parameter int WIN_Y0   = lcd_timing_pkg::WIN_Y0,
    parameter int WIN_W    = lcd_timing_pkg::WIN_W,
    parameter int WIN_H    = lcd_timing_pkg::WIN_H,
    parameter int ADDR_W   = lcd_timing_pkg::ADDR_W,
    parameter int PIPE_DLY = lcd_timing_pkg::PIPE_DLY
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              en,
    output logic              LCD_HSYNC,
    output logic              LCD_VSYNC,
    output logic              LCD_DE,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y,
    output logic              frame_start,
    output logic [ADDR_W-1:0] win_addr,
    output logic              win_valid,
    output logic              win_valid_d
);
    localparam int HT = total(H_BP, H_ACTIVE, H_FP);
    localparam int VT = total(V_BP, V_ACTIVE, V_FP);

    if (WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE || WIN_W * WIN_H > 2 ** ADDR_W ||
        H_PULSE > H_BP || V_PULSE > V_BP || HT > 2048 || VT > 1024) begin : g_bad_cfg
        $error("lcd_timing_gen: invalid timing or window parameters");
    end

    logic [10:0]       h_cnt, h_nxt;
    logic [9:0]        v_cnt, v_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              de, h_last;
    int                hi, vi, px, py;
    stage1_t           s1, s1_nxt;
    logic [3:0]        dly;

    always_comb begin
        hi = int'(h_cnt);
        vi = int'(v_cnt);
        px = hi - H_BP;
        py = vi - V_BP;
        de = px >= 0 && px < H_ACTIVE && py >= 0 && py < V_ACTIVE;
        s1_nxt = '0;
        s1_nxt.hs = en && hi < H_PULSE;
        s1_nxt.vs = en && vi < V_PULSE;
        s1_nxt.de = en && de;
        s1_nxt.fs = en && hi == 0 && vi == 0;
        s1_nxt.wv = en && de && px >= WIN_X0 && px < WIN_X0 + WIN_W && py >= WIN_Y0 && py < WIN_Y0 + WIN_H;
        s1_nxt.x = (en && de) ? 11'(px) : '0;
        s1_nxt.y = (en && de) ? 10'(py) : '0;
        // The address is a running count of window pixels, so no x*y product is needed.
        addr_nxt = (!en || s1_nxt.fs) ? '0 : s1.wv ? win_addr + ADDR_W'(1) : win_addr;
        h_last = hi == HT - 1;
        h_nxt = (!en || h_last) ? '0 : h_cnt + 11'd1;
        v_nxt = !en ? '0 : !h_last ? v_cnt : (vi == VT - 1) ? '0 : v_cnt + 10'd1;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            s1       <= '0;
            win_addr <= '0;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            s1       <= s1_nxt;
            win_addr <= addr_nxt;
        end
    end

    lcd_pipe_dly #(.WIDTH(4), .DEPTH(PIPE_DLY)) u_dly (
        .clk  (PixelClk),
        .rst_n(nRST),
        .din  ({s1.hs, s1.vs, s1.de, s1.wv}),
        .dout (dly)
    );

    assign LCD_HSYNC   = ~dly[3];
    assign LCD_VSYNC   = ~dly[2];
    assign LCD_DE      = dly[1];
    assign win_valid_d = dly[0];
    assign pix_x       = s1.x;
    assign pix_y       = s1.y;
    assign frame_start = s1.fs;
    assign win_valid   = s1.wv;
endmodule
